// File: rtl/rgb_pwm_mmio.sv
// rtl/rgb_pwm_mmio.sv - memory-mapped 8-bit PWM for led/red/green/blue
// Optional hardware fade between DUTY and shadow when RGB_PWM_FADE_EN is defined.
module rgb_pwm_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wren,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

`ifdef RGB_PWM_FADE_EN
    localparam int PERIOD_W = 23;
`else
    localparam int PERIOD_W = 24;
`endif

    logic [31:0]         duty_q, duty_d;
    logic                enable_q, enable_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [3:0][7:0]     shadow_q, shadow_d;
    logic [3:0]          out_q, out_d;

    logic [31:0]        offset;
    logic [1:0]         reg_sel;
    logic [3:0]         lane_mask;
    logic [31:0]        bit_mask;
    logic [31:0]        wdata_rep;
    logic               duty_wr, ctrl_wr;
    logic [31:0]        duty_new;
    logic               enable_new;
    logic [PRESC_W-1:0] presc_new;
    logic               tick, wrap;
    logic               busy;
    logic [31:0]        ctrl_word, status_word;

    assign offset  = addr - BASE_ADDR;
    assign hit     = offset < 32'd12;
    assign reg_sel = offset[3:2];

    // Store data arrives unshifted; replicate it so every lane sees its byte.
    always_comb begin
        lane_mask = 4'b0000;
        wdata_rep = wdata;
        case (funct3)
            3'b000: begin
                lane_mask[offset[1:0]] = 1'b1;
                wdata_rep = {4{wdata[7:0]}};
            end
            3'b001: begin
                lane_mask[{offset[1], 1'b0}] = 1'b1;
                lane_mask[{offset[1], 1'b1}] = 1'b1;
                wdata_rep = {2{wdata[15:0]}};
            end
            3'b010:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    assign duty_wr  = wren && hit && (reg_sel == 2'd0);
    assign ctrl_wr  = wren && hit && (reg_sel == 2'd1);

    assign duty_new   = (duty_q & ~bit_mask) | (wdata_rep & bit_mask);
    assign enable_new = bit_mask[0] ? wdata_rep[0] : enable_q;
    assign presc_new  = (presc_q & ~bit_mask[PRESC_W+7:8]) | (wdata_rep[PRESC_W+7:8] & bit_mask[PRESC_W+7:8]);

    assign tick = enable_q && (presc_cnt_q == presc_q);
    assign wrap = tick && (pwm_cnt_q == 8'hFF);
    assign busy = (shadow_q != duty_q);

    always_comb begin
        duty_d       = duty_wr ? duty_new : duty_q;
        enable_d     = ctrl_wr ? enable_new : enable_q;
        presc_d      = ctrl_wr ? presc_new : presc_q;
        presc_cnt_d  = presc_cnt_q;
        pwm_cnt_d    = pwm_cnt_q;
        period_cnt_d = period_cnt_q;
        shadow_d     = shadow_q;
        if (!enable_q) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = 8'h00;
            shadow_d    = duty_q;
        end else begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
            // Shrinking presc below the running count restarts the count without a tick.
            if (ctrl_wr && (presc_cnt_q > presc_d)) begin
                presc_cnt_d = '0;
            end
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + 8'd1;
            end
            if (wrap) begin
                period_cnt_d = period_cnt_q + 1'b1;
`ifdef RGB_PWM_FADE_EN
                for (int ch = 0; ch < 4; ch++) begin
                    if (shadow_q[ch] < duty_q[8*ch +: 8]) begin
                        shadow_d[ch] = shadow_q[ch] + 8'd1;
                    end else if (shadow_q[ch] > duty_q[8*ch +: 8]) begin
                        shadow_d[ch] = shadow_q[ch] - 8'd1;
                    end
                end
`else
                shadow_d = duty_q;
`endif
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            out_d[ch] = enable_q && (pwm_cnt_q < shadow_q[ch]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q       <= '0;
            enable_q     <= 1'b0;
            presc_q      <= '0;
            presc_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
            period_cnt_q <= '0;
            shadow_q     <= '0;
            out_q        <= '0;
        end else begin
            duty_q       <= duty_d;
            enable_q     <= enable_d;
            presc_q      <= presc_d;
            presc_cnt_q  <= presc_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            period_cnt_q <= period_cnt_d;
            shadow_q     <= shadow_d;
            out_q        <= out_d;
        end
    end

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[0]           = enable_q;
        ctrl_word[PRESC_W+7:8] = presc_q;
    end

`ifdef RGB_PWM_FADE_EN
    assign status_word = {busy, period_cnt_q, pwm_cnt_q};
`else
    assign status_word = {period_cnt_q, pwm_cnt_q};
`endif

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_sel)
                2'd0:    rdata = duty_q;
                2'd1:    rdata = ctrl_word;
                2'd2:    rdata = status_word;
                default: rdata = '0;
            endcase
        end
    end

    assign led   = out_q[0];
    assign red   = out_q[1];
    assign green = out_q[2];
    assign blue  = out_q[3];

endmodule

// File: tb/tb_rgb_pwm_mmio.sv
// tb/tb_rgb_pwm_mmio.sv - directed self-checking bench for rgb_pwm_mmio
module tb_rgb_pwm_mmio;

    localparam logic [31:0] BASE   = 32'hFFFF_FF00;
    localparam logic [31:0] A_DUTY = BASE;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wren;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        led, red, green, blue;

    int tests_run = 0;
    int tests_failed = 0;

    rgb_pwm_mmio #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk(clk), .reset(reset), .wren(wren), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .hit(hit),
        .led(led), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        @(negedge clk);
        addr = a; funct3 = f3; wdata = d; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic count_period(output int c_led, output int c_red, output int c_green, output int c_blue);
        c_led = 0; c_red = 0; c_green = 0; c_blue = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            c_led += int'(led); c_red += int'(red); c_green += int'(green); c_blue += int'(blue);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_pwm_255(output bit found);
        logic [31:0] s;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            bus_read(A_STAT, s);
            if (s[7:0] == 8'hFF) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        check32("reset_outputs", {28'd0, led, red, green, blue}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_DUTY, d); check32("reset_duty", d, 32'd0);
        bus_read(A_CTRL, d); check32("reset_ctrl", d, 32'd0);
        bus_read(A_STAT, d); check32("reset_status", d, 32'd0);
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] d;
        bus_write(A_DUTY, 3'b010, 32'h8080_8080);
        bus_write(A_CTRL, 3'b010, 32'h0000_0001);
        repeat (20) @(negedge clk);
        check32("midrun_outputs_on", {28'd0, led, red, green, blue}, 32'hF);
        #2 reset = 1'b1;
        #1;
        check32("async_reset_outputs", {28'd0, led, red, green, blue}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_CTRL, d); check32("midrun_ctrl_after", d, 32'd0);
        bus_read(A_DUTY, d); check32("midrun_duty_after", d, 32'd0);
        repeat (3) @(negedge clk);
        check32("midrun_outputs_after", {28'd0, led, red, green, blue}, 32'd0);
    endtask

    task automatic test_duty_sw;
        int cl, cr, cg, cb;
        bus_write(A_DUTY, 3'b010, 32'h40C0_FF00);
        bus_write(A_CTRL, 3'b010, 32'h0000_0001);
        repeat (5) @(negedge clk);
        count_period(cl, cr, cg, cb);
        check32("period_led", cl, 32'd0);
        check32("period_red", cr, 32'd255);
        check32("period_green", cg, 32'd192);
        check32("period_blue", cb, 32'd64);
    endtask

    task automatic test_prescaler;
        logic [31:0] s0, s1, s2, d;
        logic [7:0]  exp_pwm;
        logic [23:0] exp_per;
        bus_write(A_CTRL, 3'b010, 32'h0000_0301);
        bus_read(A_CTRL, d); check32("ctrl_readback", d, 32'h0000_0301);
        repeat (10) @(negedge clk);
        bus_read(A_STAT, s0);
        repeat (4) @(negedge clk);
        bus_read(A_STAT, s1);
        exp_pwm = s0[7:0] + 8'd1;
        check32("presc_step4", {24'd0, s1[7:0]}, {24'd0, exp_pwm});
        repeat (1024) @(negedge clk);
        bus_read(A_STAT, s2);
        exp_per = s1[31:8] + 24'd1;
        check32("period_step1024", {8'd0, s2[31:8]}, {8'd0, exp_per});
        check32("pwm_same_after1024", {24'd0, s2[7:0]}, {24'd0, s1[7:0]});
        bus_write(A_CTRL, 3'b010, 32'h0000_0000);
        @(negedge clk);
        bus_read(A_STAT, d);
        check32("disable_pwm_cleared", {24'd0, d[7:0]}, 32'd0);
        check32("disable_outputs", {28'd0, led, red, green, blue}, 32'd0);
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        bus_write(A_DUTY, 3'b010, 32'h0000_0000);
        bus_write(BASE + 32'h1, 3'b000, 32'h0000_00AA);
        bus_read(A_DUTY, d); check32("sb_lane1", d, 32'h0000_AA00);
        bus_write(BASE + 32'h2, 3'b001, 32'h0000_1234);
        bus_read(A_DUTY, d); check32("sh_upper", d, 32'h1234_AA00);
        bus_write(A_DUTY, 3'b011, 32'hFFFF_FFFF);
        bus_read(A_DUTY, d); check32("bad_funct3_dropped", d, 32'h1234_AA00);
        bus_write(BASE + 32'hC, 3'b000, 32'h0000_00FF);
        bus_read(A_DUTY, d); check32("out_of_window_dropped", d, 32'h1234_AA00);
        addr = BASE + 32'hB; #1;
        check32("hit_last_byte", {31'd0, hit}, 32'd1);
        addr = BASE + 32'hC; #1;
        check32("miss_after_window", {31'd0, hit}, 32'd0);
        check32("miss_rdata_zero", rdata, 32'd0);
        addr = BASE - 32'h4; #1;
        check32("miss_before_window", {31'd0, hit}, 32'd0);
    endtask

    task automatic test_wrap_write;
        int  cl, cr, cg, cb;
        bit  found;
        bus_write(A_CTRL, 3'b010, 32'h0000_0000);
        bus_write(A_DUTY, 3'b010, 32'h0000_1000);
        bus_write(A_CTRL, 3'b010, 32'h0000_0001);
        wait_pwm_255(found);
        check32("wrap_found", {31'd0, found}, 32'd1);
        addr = A_DUTY; funct3 = 3'b010; wdata = 32'h0000_8000; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
        count_period(cl, cr, cg, cb);
        check32("wrap_write_old_duty", cr, 32'd16);
        count_period(cl, cr, cg, cb);
        check32("wrap_write_new_duty", cr, 32'd128);
        bus_write(A_CTRL, 3'b010, 32'h0000_0000);
    endtask

`ifdef RGB_PWM_FADE_EN
    task automatic test_fade;
        int          cl, cr, cg, cb;
        bit          found;
        logic [31:0] s;
        int          exp_hi [5] = '{1, 2, 3, 4, 4};
        bus_write(A_CTRL, 3'b010, 32'h0000_0000);
        bus_write(A_DUTY, 3'b010, 32'h0000_0000);
        bus_write(A_CTRL, 3'b010, 32'h0000_0001);
        bus_write(A_DUTY, 3'b010, 32'h0000_0400);
        bus_read(A_STAT, s);
        check32("fade_busy_set", {31'd0, s[31]}, 32'd1);
        wait_pwm_255(found);
        check32("fade_wrap_found", {31'd0, found}, 32'd1);
        @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            count_period(cl, cr, cg, cb);
            check32("fade_red_period", cr, exp_hi[p]);
            if (p == 1) begin
                bus_read(A_STAT, s);
                check32("fade_busy_before_4th", {31'd0, s[31]}, 32'd1);
            end
            if (p == 2) begin
                bus_read(A_STAT, s);
                check32("fade_busy_cleared", {31'd0, s[31]}, 32'd0);
            end
        end
        bus_write(A_CTRL, 3'b010, 32'h0000_0000);
    endtask
`endif

    initial begin
        reset = 1'b1; wren = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        test_reset;
        test_reset_mid_run;
        test_duty_sw;
        test_prescaler;
        test_byte_lanes;
`ifdef RGB_PWM_FADE_EN
        test_fade;
`else
        test_wrap_write;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
